// File: rtl/mcpu_pkg.sv
// Shared opcode, function-code and PC-source definitions for the multicycle CPU.
package mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNC_JR  = 6'b001000;

    typedef enum logic [1:0] {
        PCS_ALU = 2'b00,
        PCS_TGT = 2'b01,
        PCS_JMP = 2'b10,
        PCS_REG = 2'b11
    } pcs_e;

    // Pseudo-direct jump: keep the PC region bits, append the word index.
    function automatic logic [31:0] jump_addr(input logic [31:0] pc, input logic [31:0] ir);
        return {pc[31:28], ir[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/mcpu_ir_fields.sv
// Combinational instruction-register field extraction and immediate sign extension.
module mcpu_ir_fields (
    input  logic [31:0] ir_i,
    output logic [5:0]  op_o,
    output logic [5:0]  func_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_sext_o
);

    assign op_o       = ir_i[31:26];
    assign func_o     = ir_i[5:0];
    assign rs_o       = ir_i[25:21];
    assign rt_o       = ir_i[20:16];
    assign rd_o       = ir_i[15:11];
    assign imm_sext_o = {{16{ir_i[15]}}, ir_i[15:0]};

endmodule

// File: rtl/mcpu_pc_ir_unit.sv
// Fetch-side register stage: PC, IR, branch target, MDR and retired-fetch counter.
// Optional bne support via macro MCPU_BNE_EN (default build treats bne as beq).
module mcpu_pc_ir_unit
    import mcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcw,
    input  logic             pcwc,
    input  logic [1:0]       pcs,
    input  logic             irw,
    input  logic             tw,
    input  logic             zero,
    input  logic [31:0]      alu_res,
    input  logic [31:0]      reg_a,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic [5:0]       op,
    output logic [5:0]       func,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [31:0]      imm_sext,
    output logic [31:0]      target,
    output logic [31:0]      mdr,
    output logic [CNT_W-1:0] instret,
    output logic             pc_misalign
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      mdr_q;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mis_q, mis_d;
    logic             take, pc_we;
    logic [31:0]      pc_src;

    mcpu_ir_fields u_fields (
        .ir_i       (ir_q),
        .op_o       (op),
        .func_o     (func),
        .rs_o       (rs),
        .rt_o       (rt),
        .rd_o       (rd),
        .imm_sext_o (imm_sext)
    );

    always_comb begin
`ifdef MCPU_BNE_EN
        take = (op == OP_BNE) ? ~zero : zero;
`else
        take = zero;
`endif
        pc_we = pcw | (pcwc & take);

        unique case (pcs_e'(pcs))
            PCS_ALU: pc_src = alu_res;
            PCS_TGT: pc_src = target_q;
            PCS_JMP: pc_src = jump_addr(pc_q, ir_q);
            PCS_REG: pc_src = reg_a;
            default: pc_src = alu_res;
        endcase

        // The written PC is always word aligned; a dropped low bit is remembered.
        pc_d      = pc_we ? {pc_src[31:2], 2'b00} : pc_q;
        mis_d     = mis_q | (pc_we & (pc_src[1:0] != 2'b00));
        ir_d      = irw ? mem_rdata : ir_q;
        target_d  = tw ? alu_res : target_q;
        instret_d = irw ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            target_q  <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            target_q  <= target_d;
            mdr_q     <= mem_rdata;
            instret_q <= instret_d;
            mis_q     <= mis_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign target      = target_q;
    assign mdr         = mdr_q;
    assign instret     = instret_q;
    assign pc_misalign = mis_q;

endmodule
